// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB requester.
// Takes one command on the cmd channel, runs the SETUP and ACCESS phases
// (waiting on PREADY), and returns read data / error status on the rsp channel.
// A wait-state watchdog aborts an ACCESS phase that a hung slave never completes.
//
// Handshake rule for both cmd and rsp channels: a transfer happens on a rising
// PCLK edge where valid and ready are both high. The producer holds valid and its
// payload stable until that edge. The consumer may change ready at any time.
module apb_master_bridge #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   // command channel
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic                  cmd_write,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   // response channel
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   // APB requester pins
   output logic                  PSELx,
   output logic                  PENABLE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PWRITE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic                  PREADY,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PSLVERR,
   // FSM state for observation (IDLE=0, SETUP=1, ACCESS=2, RESP=3)
   output logic [1:0]            dbg_state
);

   // Counter must hold TIMEOUT_CYCLES; keep at least one bit when the watchdog is off.
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX   = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES) : '0;
   localparam logic [CW-1:0] LAST_WAIT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t                state, state_nxt;
   logic [CW-1:0]         wait_cnt, wait_cnt_nxt;
   logic                  psel_nxt, penable_nxt, pwrite_nxt;
   logic [ADDR_WIDTH-1:0] paddr_nxt;
   logic [DATA_WIDTH-1:0] pwdata_nxt;
   logic                  rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
   logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
   logic                  timeout_hit;

   // The current ACCESS cycle is the last PREADY-low cycle the watchdog tolerates.
   assign timeout_hit = (TIMEOUT_CYCLES > 0) && (wait_cnt == LAST_WAIT);

   // Commands are only taken in IDLE, and never while reset is asserted.
   assign cmd_ready = (state == IDLE) && PRESETn;
   assign dbg_state = state;

   // State and output registers; reset discards any transfer in flight.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         PSELx       <= 1'b0;
         PENABLE     <= 1'b0;
         PADDR       <= '0;
         PWRITE      <= 1'b0;
         PWDATA      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_cnt_nxt;
         PSELx       <= psel_nxt;
         PENABLE     <= penable_nxt;
         PADDR       <= paddr_nxt;
         PWRITE      <= pwrite_nxt;
         PWDATA      <= pwdata_nxt;
         rsp_valid   <= rsp_valid_nxt;
         rsp_rdata   <= rsp_rdata_nxt;
         rsp_err     <= rsp_err_nxt;
         rsp_timeout <= rsp_timeout_nxt;
      end
   end

   // Next-state selection.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (cmd_valid) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (PREADY || timeout_hit) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs; anything not assigned holds.
   always_comb begin
      wait_cnt_nxt    = wait_cnt;
      psel_nxt        = PSELx;
      penable_nxt     = PENABLE;
      paddr_nxt       = PADDR;
      pwrite_nxt      = PWRITE;
      pwdata_nxt      = PWDATA;
      rsp_valid_nxt   = rsp_valid;
      rsp_rdata_nxt   = rsp_rdata;
      rsp_err_nxt     = rsp_err;
      rsp_timeout_nxt = rsp_timeout;
      unique case (state)
         IDLE: begin
            penable_nxt = 1'b0;
            if (cmd_valid) begin
               psel_nxt   = 1'b1;
               paddr_nxt  = cmd_addr;
               pwrite_nxt = cmd_write;
               pwdata_nxt = cmd_wdata;
            end else begin
               psel_nxt = 1'b0;
            end
         end
         SETUP: begin
            penable_nxt  = 1'b1;
            wait_cnt_nxt = '0;
         end
         ACCESS: begin
            if (PREADY) begin
               // Slave completion wins over a watchdog expiring in the same cycle.
               psel_nxt        = 1'b0;
               penable_nxt     = 1'b0;
               rsp_valid_nxt   = 1'b1;
               rsp_rdata_nxt   = PWRITE ? '0 : PRDATA;
               rsp_err_nxt     = PSLVERR;
               rsp_timeout_nxt = 1'b0;
            end else if (timeout_hit) begin
               psel_nxt        = 1'b0;
               penable_nxt     = 1'b0;
               rsp_valid_nxt   = 1'b1;
               rsp_rdata_nxt   = '0;
               rsp_err_nxt     = 1'b1;
               rsp_timeout_nxt = 1'b1;
            end else if (wait_cnt != CNT_MAX) begin
               wait_cnt_nxt = wait_cnt + CW'(1);
            end
         end
         RESP: begin
            if (rsp_ready) rsp_valid_nxt = 1'b0;
         end
         default: begin
            psel_nxt    = 1'b0;
            penable_nxt = 1'b0;
         end
      endcase
   end

endmodule
